// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter feeding a 2-to-4 decoder.
// Grants are held until done, request drop, or an optional hold-time limit.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_gnt_idx,
  output logic [1:0] o_sel,
  output logic       o_en,
  output logic       o_preempt
);

  // HOLD_MAX = 0 wraps HoldLast to 255, but LimitOn masks the compare.
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);
  localparam logic       LimitOn  = (HOLD_MAX != 0);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  state_e     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_gnt_idx;
  logic [1:0] r_sel;
  logic       r_en;
  logic       r_preempt;

  state_e     w_state_d;
  logic [1:0] w_ptr_d;
  logic [7:0] w_hold_cnt_d;
  logic [1:0] w_gnt_idx_d;
  logic [1:0] w_sel_d;
  logic       w_en_d;
  logic       w_preempt_d;

  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_pick;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_tmo;

  // Rotate requests so bit 0 is the requester at ptr, then priority-encode.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = w_req2[r_ptr +: 4];

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0]) begin
      w_off = 2'd0;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
    end
  end

  assign w_pick     = r_ptr + w_off;
  assign w_rel_done = i_done;
  assign w_rel_drop = ~i_req[r_gnt_idx];
  assign w_rel_tmo  = LimitOn && (r_hold_cnt == HoldLast);

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_hold_cnt_d = r_hold_cnt;
    w_gnt_idx_d  = r_gnt_idx;
    w_sel_d      = r_sel;
    w_en_d       = r_en;
    w_preempt_d  = 1'b0;
    case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_d    = StGrant;
          w_gnt_idx_d  = w_pick;
          w_sel_d      = {w_pick[0], w_pick[1]};
          w_en_d       = 1'b1;
          w_hold_cnt_d = 8'd0;
        end
      end
      StGrant: begin
        if (w_rel_done || w_rel_drop || w_rel_tmo) begin
          w_state_d   = StIdle;
          w_en_d      = 1'b0;
          w_ptr_d     = r_gnt_idx + 2'd1;
          // Only a pure timeout counts as preemption.
          w_preempt_d = w_rel_tmo && !w_rel_done && !w_rel_drop;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_cnt_d = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= 2'd0;
      r_hold_cnt <= 8'd0;
      r_gnt_idx  <= 2'd0;
      r_sel      <= 2'd0;
      r_en       <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_gnt_idx  <= w_gnt_idx_d;
      r_sel      <= w_sel_d;
      r_en       <= w_en_d;
      r_preempt  <= w_preempt_d;
    end
  end

  assign o_gnt_idx = r_gnt_idx;
  assign o_sel     = r_sel;
  assign o_en      = r_en;
  assign o_preempt = r_preempt;

endmodule
